// File: rtl/mips_hazard_scoreboard_if.sv
// Decode-stage hazard-check bus between the decode stage and the scoreboard.
interface mips_hazard_scoreboard_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned LONG_LAT   = 5
);
    localparam int unsigned CNT_W = $clog2(LONG_LAT + 1);

    logic                          issue_valid_D;
    logic                          long_start_D;
    logic [NUM_SRC*REG_ADDR_W-1:0] src_addr_D;
    logic [NUM_SRC-1:0]            src_used_D;
    logic [REG_ADDR_W-1:0]         dest_addr_D;
    logic                          reg_write_D;
    logic                          stall;
    logic [2:0]                    stall_cause;
    logic [CNT_W-1:0]              inflight_cnt;
    logic                          wdog_trip;

    modport master (
        output issue_valid_D, long_start_D, src_addr_D, src_used_D, dest_addr_D, reg_write_D,
        input  stall, stall_cause, inflight_cnt, wdog_trip
    );

    modport slave (
        input  issue_valid_D, long_start_D, src_addr_D, src_used_D, dest_addr_D, reg_write_D,
        output stall, stall_cause, inflight_cnt, wdog_trip
    );
endinterface

// File: rtl/mips_hazard_scoreboard.sv
// Long-latency op scoreboard: RAW, write-port and WAW stall detection for decode.
// Optional stall watchdog enabled by defining MIPS_STALL_WDOG_EN.
module mips_hazard_scoreboard #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned LONG_LAT   = 5,
    parameter int unsigned SHORT_LAT  = 2,
    parameter int unsigned WDOG_LIMIT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    mips_hazard_scoreboard_if.slave  dif
);
    localparam int unsigned CNT_W    = $clog2(LONG_LAT + 1);
    localparam int unsigned PORT_STG = LONG_LAT - SHORT_LAT - 1;

    if ((LONG_LAT <= SHORT_LAT) || (SHORT_LAT < 1) || (WDOG_LIMIT < 1)) begin : g_param_check
        $error("mips_hazard_scoreboard: illegal latency or watchdog parameters");
    end

    logic [LONG_LAT-1:0]   vld_q;
    logic [REG_ADDR_W-1:0] dst_q [LONG_LAT];
    logic [CNT_W-1:0]      cnt_q;

    logic                  raw_c;
    logic                  port_c;
    logic                  waw_c;
    logic                  raw_stall_c;
    logic                  stall_c;
    logic                  short_wr_c;
    logic                  load_c;
    logic [LONG_LAT-1:0]   vld_d;
    logic [CNT_W-1:0]      cnt_d;

    assign short_wr_c = dif.issue_valid_D && dif.reg_write_D && !dif.long_start_D;

    // Hazard detection against in-flight long ops; the last stage is covered by write-through.
    always_comb begin
        raw_c = 1'b0;
        waw_c = 1'b0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            for (int i = 0; i < int'(LONG_LAT) - 1; i++) begin
                if (dif.src_used_D[k] &&
                    (dif.src_addr_D[k*REG_ADDR_W +: REG_ADDR_W] != '0) &&
                    vld_q[i] &&
                    (dif.src_addr_D[k*REG_ADDR_W +: REG_ADDR_W] == dst_q[i])) begin
                    raw_c = 1'b1;
                end
            end
        end
        raw_c = raw_c && dif.issue_valid_D;
        for (int i = 0; i < int'(PORT_STG); i++) begin
            if (vld_q[i] && (dst_q[i] == dif.dest_addr_D)) begin
                waw_c = 1'b1;
            end
        end
        waw_c  = waw_c && short_wr_c && (dif.dest_addr_D != '0);
        port_c = short_wr_c && vld_q[PORT_STG];
    end

    assign raw_stall_c = raw_c || port_c || waw_c;
    assign load_c      = dif.issue_valid_D && dif.long_start_D && !stall_c;
    assign vld_d       = {vld_q[LONG_LAT-2:0], load_c};

    // Occupancy of the next shift-register state, registered with the valid bits.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < int'(LONG_LAT); i++) begin
            cnt_d = cnt_d + CNT_W'(vld_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(LONG_LAT); i++) begin
                dst_q[i] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            cnt_q    <= cnt_d;
            dst_q[0] <= load_c ? dif.dest_addr_D : '0;
            for (int i = 1; i < int'(LONG_LAT); i++) begin
                dst_q[i] <= dst_q[i-1];
            end
        end
    end

`ifdef MIPS_STALL_WDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            trip_q;
    logic            wd_fire_c;

    // Release one stall cycle after WDOG_LIMIT consecutive stalled cycles.
    assign wd_fire_c = raw_stall_c && (wd_cnt_q == WD_W'(WDOG_LIMIT));
    assign stall_c   = raw_stall_c && !wd_fire_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
            trip_q   <= 1'b0;
        end else begin
            if (!raw_stall_c || wd_fire_c) begin
                wd_cnt_q <= '0;
            end else begin
                wd_cnt_q <= wd_cnt_q + WD_W'(1);
            end
            if (wd_fire_c) begin
                trip_q <= 1'b1;
            end
        end
    end

    assign dif.wdog_trip = trip_q || wd_fire_c;
`else
    assign stall_c       = raw_stall_c;
    assign dif.wdog_trip = 1'b0;
`endif

    assign dif.stall        = stall_c;
    assign dif.stall_cause  = {waw_c, port_c, raw_c};
    assign dif.inflight_cnt = cnt_q;
endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Directed self-checking bench for mips_hazard_scoreboard (LONG_LAT=5, SHORT_LAT=2).
module tb_mips_hazard_scoreboard;
    localparam int unsigned LL = 5;
`ifdef MIPS_STALL_WDOG_EN
    localparam int unsigned WDL = 3;
`else
    localparam int unsigned WDL = 16;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mips_hazard_scoreboard_if #(.REG_ADDR_W(5), .NUM_SRC(2), .LONG_LAT(LL)) dif ();

    mips_hazard_scoreboard #(
        .REG_ADDR_W(5), .NUM_SRC(2), .LONG_LAT(LL), .SHORT_LAT(2), .WDOG_LIMIT(WDL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dif(dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic iv, input logic lg, input logic rw, input logic [4:0] dst,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
        dif.issue_valid_D = iv;
        dif.long_start_D  = lg;
        dif.reg_write_D   = rw;
        dif.dest_addr_D   = dst;
        dif.src_addr_D    = {s1, s0};
        dif.src_used_D    = used;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (LL + 1) next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        nop();
        next_cycle();
        next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (dif.stall !== 1'b0) begin
            $display("FAIL reset_stall: got %b want 0", dif.stall); failures++;
        end
        checks++;
        if (dif.stall_cause !== 3'b000) begin
            $display("FAIL reset_cause: got %b want 000", dif.stall_cause); failures++;
        end
        checks++;
        if (dif.inflight_cnt !== 3'd0) begin
            $display("FAIL reset_inflight: got %0d want 0", dif.inflight_cnt); failures++;
        end
        checks++;
        if (dif.wdog_trip !== 1'b0) begin
            $display("FAIL reset_wdog: got %b want 0", dif.wdog_trip); failures++;
        end
        next_cycle();
    endtask

    task automatic test_raw();
        logic       exp_stall;
        logic [2:0] exp_cause;
        logic       exp_trip;
        drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 2'b00);
        #1;
        checks++;
        if (dif.stall !== 1'b0) begin
            $display("FAIL raw_c0_stall: got %b want 0", dif.stall); failures++;
        end
        next_cycle();
        for (int c = 1; c <= 5; c++) begin
            drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 2'b01);
            #1;
            exp_cause = (c <= 4) ? 3'b001 : 3'b000;
            exp_stall = (c <= 4);
            exp_trip  = 1'b0;
`ifdef MIPS_STALL_WDOG_EN
            if (c == 4) exp_stall = 1'b0;
            if (c >= 4) exp_trip = 1'b1;
`endif
            checks++;
            if (dif.stall !== exp_stall) begin
                $display("FAIL raw_stall c%0d: got %b want %b", c, dif.stall, exp_stall); failures++;
            end
            checks++;
            if (dif.stall_cause !== exp_cause) begin
                $display("FAIL raw_cause c%0d: got %b want %b", c, dif.stall_cause, exp_cause); failures++;
            end
            checks++;
            if (dif.wdog_trip !== exp_trip) begin
                $display("FAIL raw_wdog c%0d: got %b want %b", c, dif.wdog_trip, exp_trip); failures++;
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_port();
        drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 5'd0, 2'b00);
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            if (c >= 3) drive(1'b1, 1'b0, 1'b1, 5'd3, 5'd1, 5'd2, 2'b11);
            else        nop();
            #1;
            checks++;
            if (dif.stall !== (c == 3)) begin
                $display("FAIL port_stall c%0d: got %b want %b", c, dif.stall, (c == 3)); failures++;
            end
            checks++;
            if (dif.stall_cause !== ((c == 3) ? 3'b010 : 3'b000)) begin
                $display("FAIL port_cause c%0d: got %b want %b", c, dif.stall_cause,
                         ((c == 3) ? 3'b010 : 3'b000)); failures++;
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_waw();
        logic [2:0] exp_cause;
        drive(1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 2'b00);
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, 1'b0, 1'b1, 5'd9, 5'd0, 5'd0, 2'b00);
            #1;
            exp_cause = (c <= 2) ? 3'b100 : ((c == 3) ? 3'b010 : 3'b000);
            checks++;
            if (dif.stall_cause !== exp_cause) begin
                $display("FAIL waw_cause c%0d: got %b want %b", c, dif.stall_cause, exp_cause); failures++;
            end
            checks++;
            if (dif.stall !== (exp_cause != 3'b000)) begin
                $display("FAIL waw_stall c%0d: got %b want %b", c, dif.stall, (exp_cause != 3'b000)); failures++;
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_zero();
        drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00);
        next_cycle();
        drive(1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b11);
        #1;
        checks++;
        if (dif.stall_cause !== 3'b000) begin
            $display("FAIL zero_cause: got %b want 000", dif.stall_cause); failures++;
        end
        checks++;
        if (dif.stall !== 1'b0) begin
            $display("FAIL zero_stall: got %b want 0", dif.stall); failures++;
        end
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin
                nop();
                #1;
            end
            checks++;
            if (dif.inflight_cnt !== ((c <= 5) ? 3'd1 : 3'd0)) begin
                $display("FAIL zero_inflight c%0d: got %0d want %0d", c, dif.inflight_cnt,
                         ((c <= 5) ? 1 : 0)); failures++;
            end
            next_cycle();
        end
        drain();
    endtask

    task automatic test_src_slot();
        drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 2'b00);
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd7, 5'd5, 2'b10);
        #1;
        checks++;
        if (dif.stall !== 1'b0) begin
            $display("FAIL slot_unused_stall: got %b want 0", dif.stall); failures++;
        end
        next_cycle();
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd7, 2'b10);
        #1;
        checks++;
        if (dif.stall_cause !== 3'b001) begin
            $display("FAIL slot1_cause: got %b want 001", dif.stall_cause); failures++;
        end
        next_cycle();
        drain();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 2; c++) begin
            drive(1'b1, 1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 2'b00);
            if (c == 2) rst = 1'b1;
            #1;
            checks++;
            if (dif.stall !== 1'b0) begin
                $display("FAIL b2b_stall c%0d: got %b want 0", c, dif.stall); failures++;
            end
            checks++;
            if (dif.inflight_cnt !== 3'(c)) begin
                $display("FAIL b2b_inflight c%0d: got %0d want %0d", c, dif.inflight_cnt, c); failures++;
            end
            next_cycle();
        end
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 5'd10, 5'd10, 5'd10, 2'b11);
        #1;
        checks++;
        if (dif.stall !== 1'b0) begin
            $display("FAIL midrst_stall: got %b want 0", dif.stall); failures++;
        end
        checks++;
        if (dif.stall_cause !== 3'b000) begin
            $display("FAIL midrst_cause: got %b want 000", dif.stall_cause); failures++;
        end
        checks++;
        if (dif.inflight_cnt !== 3'd0) begin
            $display("FAIL midrst_inflight: got %0d want 0", dif.inflight_cnt); failures++;
        end
        checks++;
        if (dif.wdog_trip !== 1'b0) begin
            $display("FAIL midrst_wdog: got %b want 0", dif.wdog_trip); failures++;
        end
        next_cycle();
        nop();
        #1;
        checks++;
        if (dif.inflight_cnt !== 3'd0) begin
            $display("FAIL midrst_inflight_c4: got %0d want 0", dif.inflight_cnt); failures++;
        end
        drain();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        nop();
        test_reset();
        test_raw();
        test_port();
        test_waw();
        test_zero();
        test_src_slot();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
